// File: rtl/synth_audio_pkg.sv
// Shared audio constants and types for the I2S transmit path.
package synth_audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int I2S_SLOTS = 32;
  localparam int SLOT_W    = $clog2(I2S_SLOTS);
  localparam int BIT_W     = $clog2(SAMPLE_W);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [SLOT_W-1:0]          slot_t;

  // Slot in which the next frame word is latched (left MSB slot).
  localparam slot_t LOAD_SLOT  = slot_t'(1);
  // Slot held during reset so the first falling edge lands on slot 0.
  localparam slot_t RESET_SLOT = slot_t'(I2S_SLOTS - 1);

  // Bit of the frame word carried in a slot. Left slots 1..16 give 15..0,
  // right slots 17..31 give 15..1 and slot 0 gives bit 0; all of these are
  // (16 - slot) mod 16, i.e. the negated low nibble of the slot index.
  function automatic logic [BIT_W-1:0] slot_bit(input slot_t slot);
    return {BIT_W{1'b0}} - slot[BIT_W-1:0];
  endfunction

endpackage

// File: rtl/synth_bclk_gen.sv
// Bit-clock divider: bclk toggles every BCLK_HALF clk cycles; fall_strobe
// marks the cycle whose clock edge drives bclk from 1 to 0.
module synth_bclk_gen #(
  parameter int BCLK_HALF = 8
) (
  input  logic clk,
  input  logic reset_n,
  output logic bclk,
  output logic fall_strobe
);

  logic [7:0] div_cnt;
  logic       wrap;

  assign wrap        = (div_cnt == 8'(BCLK_HALF - 1));
  assign fall_strobe = wrap & bclk;

  // Half-period counter and registered bclk toggle on each wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/synth_i2s_tx.sv
// Mono-to-stereo I2S transmitter: a one-deep sample buffer feeds a frame
// word that is serialized MSB first on both channels, one bclk late.
module synth_i2s_tx
  import synth_audio_pkg::*;
#(
  parameter int BCLK_HALF = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  logic    fall_strobe;
  slot_t   slot;
  slot_t   slot_next;
  sample_t buffer;
  logic    buffer_full;
  sample_t frame_word;
  sample_t frame_next;
  logic    load_edge;
  logic    xfer;

  synth_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .bclk        (bclk),
    .fall_strobe (fall_strobe)
  );

  assign sample_ready = ~buffer_full;
  assign xfer         = sample_valid & sample_ready;
  assign slot_next    = slot + slot_t'(1);
  assign load_edge    = fall_strobe & (slot_next == LOAD_SLOT);

  // Word for the coming frame: buffered sample first, else a same-cycle
  // bypass from the input, else repeat the previous word.
  always_comb begin
    frame_next = frame_word;
    if (load_edge) begin
      if (buffer_full) begin
        frame_next = buffer;
      end else if (xfer) begin
        frame_next = sample_in;
      end
    end
  end

  // Slot counter and serializer; outputs move only on bclk falling edges.
  // sdata uses frame_next so the left MSB appears with the slot-1 load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot  <= RESET_SLOT;
      lrclk <= 1'b1;
      sdata <= 1'b0;
    end else if (fall_strobe) begin
      slot  <= slot_next;
      lrclk <= slot_next[SLOT_W-1];
      sdata <= frame_next[slot_bit(slot_next)];
    end
  end

  // Sample buffer, frame word and underrun flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buffer      <= '0;
      buffer_full <= 1'b0;
      frame_word  <= '0;
      underrun    <= 1'b0;
    end else begin
      frame_word <= frame_next;
      underrun   <= load_edge & ~buffer_full & ~xfer;
      if (load_edge) begin
        buffer_full <= 1'b0;
      end else if (xfer) begin
        buffer      <= sample_in;
        buffer_full <= 1'b1;
      end
    end
  end

endmodule

// File: doc/synth_i2s_tx.md
SYNTH_I2S_TX -- requirements
Module: synth_i2s_tx

Interface
REQ-001 Parameter BCLK_HALF, default 8: clk cycles per bclk half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 sample_in  input  16  signed mono audio sample, two's complement.
REQ-005 sample_valid  input  1  sample_in holds a sample to transfer.
REQ-006 sample_ready  output  1  block can accept a sample this cycle.
REQ-007 bclk  output  1  I2S bit clock.
REQ-008 lrclk  output  1  I2S word select; 0 = left, 1 = right.
REQ-009 sdata  output  1  I2S serial data, MSB first.
REQ-010 underrun  output  1  one-cycle pulse when a frame starts with no new sample.

Function
REQ-011 A transfer SHALL occur on any cycle where sample_valid and sample_ready are both 1.
REQ-012 The block SHALL hold one sample in a buffer; sample_ready = NOT buffer_full, driven combinationally from the register.
REQ-013 div_cnt SHALL count 0..BCLK_HALF-1 and wrap; bclk SHALL toggle in each wrap cycle, giving a bclk period of 2*BCLK_HALF clk cycles.
REQ-014 A 5-bit slot counter SHALL advance modulo 32 on every bclk falling transition (bclk 1->0 registered in the same cycle).
REQ-015 lrclk SHALL equal slot[4]: 0 for slots 0..15 and 1 for slots 16..31.
REQ-016 On entry to slot 1, frame_word SHALL load the buffered sample and clear buffer_full.
REQ-017 Slots 1..16 SHALL drive sdata = frame_word[16-slot] (left channel).
REQ-018 Slots 17..31 SHALL drive sdata = frame_word[32-slot], and slot 0 SHALL drive frame_word[0]; this is the right channel (same word, one-bclk I2S delay).
REQ-019 On entry to slot 1 with the buffer empty and a transfer in the same cycle, sample_in SHALL bypass directly into frame_word; the buffer stays empty and underrun stays 0.
REQ-020 On entry to slot 1 with the buffer empty and no transfer, frame_word SHALL keep its previous value and underrun SHALL pulse high for exactly that cycle.
REQ-021 A transfer while the buffer is empty at any other time SHALL set buffer_full; it is not possible while full because ready is 0.
REQ-022 sdata and lrclk SHALL change only in bclk falling-edge cycles and SHALL be stable while bclk is 1.
REQ-023 With BCLK_HALF = B and cycle 0 the first cycle after reset release, bclk SHALL first read 1 at cycle B, reach slot 0 at cycle 2B and slot 1 (left MSB) at cycle 4B.

Reset
REQ-024 While reset_n = 0 on a clk edge: div_cnt = 0, bclk = 0, slot = 31, lrclk = 1, sdata = 0, frame_word = 0, buffer_full = 0, underrun = 0; hence sample_ready = 1.
REQ-025 Reset asserted mid-frame SHALL discard the buffer and frame_word with no partial-word completion; output timing SHALL restart per REQ-023.

Structure
REQ-026 Package synth_audio_pkg SHALL hold SAMPLE_W = 16, I2S_SLOTS = 32, typedef sample_t (signed 16-bit) and the slot-index typedef.
REQ-027 The bclk divider and falling-edge strobe SHALL be sub-module synth_bclk_gen (inputs clk, reset_n; outputs bclk, fall_strobe); slot, buffer and serializer logic stay in synth_i2s_tx.
REQ-028 Total RTL SHALL be single-clock with no gated or derived clocks; bclk is a registered data output.

Verification
REQ-029 BCLK_HALF=2; push 0x8001 at cycle 0 -> sample_ready 0 from cycle 1; left slots 1..16 sdata = 1,0x14,1; right slots 17..31 then 0 repeat the word; lrclk 0 for slots 0..15.
REQ-030 No second sample pushed -> underrun pulses exactly one cycle at the next slot-1 entry; next frame serializes 0x8001 again.
REQ-031 Push 0x1234 then hold valid with 0x5678 -> 0x5678 is accepted in the slot-1 entry cycle after ready rises; frames carry 0x1234 then 0x5678.
REQ-032 Buffer empty, valid with 0x7FFF asserted exactly in the slot-1 entry cycle -> bypass: left MSB 0, remaining 15 bits 1; underrun stays 0; sample_ready stays 1.
REQ-033 reset_n low for 1 cycle at slot 20 -> all outputs take REQ-024 values next cycle; first left MSB appears 4*BCLK_HALF cycles after release.
REQ-034 BCLK_HALF=255, 0xFFFF (-1) frames -> bclk period 510 cycles; sdata constant 1 across all slots of a full frame; lrclk period 32*510 cycles.
